pipe_stall_ctrl: RTL and testbench

Parametrised pipeline stall controller for the RISC core. It decides, every cycle, which pipeline stages may advance. It inserts programmable wait states for program-memory and data-memory accesses that fall in the slow address region, and reports bubbles. Stage advance is signalled with enables; no clock gating is performed. It sits between the memory address paths (fetch PC, data address/rwb) and every stage register bank.

---
 rtl/core_pkg.sv | 27 ++
 rtl/wait_state_timer.sv | 74 +++++++
 rtl/pipe_stall_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and defaults for the pipeline stall controller and its wait-state timers.
// Holds the timer state enum, default region limits/wait counts and the counter-width helper.
package core_pkg;

  typedef enum logic {
    WT_IDLE = 1'b0,
    WT_WAIT = 1'b1
  } wt_state_t;

  localparam logic [15:0] DEF_PM_FAST_LIMIT = 16'h1000;
  localparam logic [15:0] DEF_DM_FAST_LIMIT = 16'h1000;
  localparam int          DEF_PM_WAIT       = 2;
  localparam int          DEF_DM_RD_WAIT    = 2;
  localparam int          DEF_DM_WR_WAIT    = 1;

  // Wide enough to hold the largest wait count; never narrower than one bit.
  function automatic int wait_cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wait_state_timer.sv
// Per-channel wait-state timer: fast accesses are ready in the same cycle, slow ones after wait_val cycles.
// Latency 0 (fast) or wait_val cycles (slow); a dropped request aborts the wait without issuing rdy.
module wait_state_timer
  import core_pkg::*;
#(
  parameter int             AW    = 16,
  parameter logic [AW-1:0]  LIMIT = AW'(16'h1000),
  parameter int             CW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic [CW-1:0] wait_val,
  output logic          rdy,
  output logic          busy
);

  wt_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          slow;
  logic          rdy_raw;

  // A zero wait count makes the whole region behave as fast.
  assign slow = (addr >= LIMIT) && (wait_val != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_raw = 1'b0;
    case (state_q)
      WT_IDLE: begin
        if (req) begin
          if (slow) begin
            state_d = WT_WAIT;
            cnt_d   = wait_val - CW'(1);
          end else begin
            rdy_raw = 1'b1;
          end
        end
      end
      WT_WAIT: begin
        // Address and wait value are deliberately not re-examined while waiting.
        if (!req) begin
          state_d = WT_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          rdy_raw = 1'b1;
          state_d = WT_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = WT_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WT_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rdy  = rdy_raw & rst_n;
  assign busy = (state_q == WT_WAIT);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: per-stage advance enables and bubble flags from PM/DM wait-state timers.
// Latency 0 on the fast path, W cycles on slow regions; run=0 freezes all stages while timers keep counting.
// Optional STALL_PERF_EN adds saturating 32-bit per-channel stall counters.
module pipe_stall_ctrl
  import core_pkg::*;
#(
  parameter int            NSTAGE        = 4,
  parameter int            MEM_STAGE     = 2,
  parameter int            AW            = 16,
  parameter logic [AW-1:0] PM_FAST_LIMIT = AW'(DEF_PM_FAST_LIMIT),
  parameter logic [AW-1:0] DM_FAST_LIMIT = AW'(DEF_DM_FAST_LIMIT),
  parameter int            PM_WAIT       = DEF_PM_WAIT,
  parameter int            DM_RD_WAIT    = DEF_DM_RD_WAIT,
  parameter int            DM_WR_WAIT    = DEF_DM_WR_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              pm_req,
  input  logic [AW-1:0]     pm_add,
  input  logic              dm_req,
  input  logic [AW-1:0]     dm_add,
  input  logic              rwb,
  output logic              pm_rdy,
  output logic              dm_rdy,
  output logic [NSTAGE-1:0] stage_en,
  output logic [NSTAGE-1:0] bubble,
  output logic              busy
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]       pm_stall_cnt,
  output logic [31:0]       dm_stall_cnt
`endif
);

  localparam int CW = wait_cnt_width(PM_WAIT, DM_RD_WAIT, DM_WR_WAIT);

  logic [CW-1:0] pm_wait_val;
  logic [CW-1:0] dm_wait_val;
  logic          pm_busy, dm_busy;
  logic          pm_stall, dm_stall;

  assign pm_wait_val = CW'(PM_WAIT);
  // The timer only latches this on IDLE->WAIT, so rwb is effectively sampled there.
  assign dm_wait_val = rwb ? CW'(DM_RD_WAIT) : CW'(DM_WR_WAIT);

  wait_state_timer #(
    .AW    (AW),
    .LIMIT (PM_FAST_LIMIT),
    .CW    (CW)
  ) u_pm_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (pm_req),
    .addr     (pm_add),
    .wait_val (pm_wait_val),
    .rdy      (pm_rdy),
    .busy     (pm_busy)
  );

  wait_state_timer #(
    .AW    (AW),
    .LIMIT (DM_FAST_LIMIT),
    .CW    (CW)
  ) u_dm_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (dm_req),
    .addr     (dm_add),
    .wait_val (dm_wait_val),
    .rdy      (dm_rdy),
    .busy     (dm_busy)
  );

  assign pm_stall = pm_req & ~pm_rdy;
  assign dm_stall = dm_req & ~dm_rdy;
  assign busy     = pm_busy | dm_busy;

  // Fetch freezes on a PM stall; a DM stall freezes fetch through the memory stage.
  always_comb begin
    stage_en = '0;
    bubble   = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      stage_en[i] = run & rst_n;
      if ((i == 0) && pm_stall) stage_en[i] = 1'b0;
      if ((i <= MEM_STAGE) && dm_stall) stage_en[i] = 1'b0;
    end
    for (int i = 1; i < NSTAGE; i++) begin
      bubble[i] = stage_en[i] & ~stage_en[i-1];
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] pm_stall_cnt_q, pm_stall_cnt_d;
  logic [31:0] dm_stall_cnt_q, dm_stall_cnt_d;

  always_comb begin
    pm_stall_cnt_d = pm_stall_cnt_q;
    dm_stall_cnt_d = dm_stall_cnt_q;
    if (pm_stall && (pm_stall_cnt_q != '1)) pm_stall_cnt_d = pm_stall_cnt_q + 32'd1;
    if (dm_stall && (dm_stall_cnt_q != '1)) dm_stall_cnt_d = dm_stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_stall_cnt_q <= '0;
      dm_stall_cnt_q <= '0;
    end else begin
      pm_stall_cnt_q <= pm_stall_cnt_d;
      dm_stall_cnt_q <= dm_stall_cnt_d;
    end
  end

  assign pm_stall_cnt = pm_stall_cnt_q;
  assign dm_stall_cnt = dm_stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with default parameters (NSTAGE=4, MEM_STAGE=2, waits 2/2/1).
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        pm_req;
  logic [15:0] pm_add;
  logic        dm_req;
  logic [15:0] dm_add;
  logic        rwb;
  logic        pm_rdy;
  logic        dm_rdy;
  logic [3:0]  stage_en;
  logic [3:0]  bubble;
  logic        busy;
`ifdef STALL_PERF_EN
  logic [31:0] pm_stall_cnt;
  logic [31:0] dm_stall_cnt;
`endif

  int total;
  int bad;

  pipe_stall_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .pm_req   (pm_req),
    .pm_add   (pm_add),
    .dm_req   (dm_req),
    .dm_add   (dm_add),
    .rwb      (rwb),
    .pm_rdy   (pm_rdy),
    .dm_rdy   (dm_rdy),
    .stage_en (stage_en),
    .bubble   (bubble),
    .busy     (busy)
`ifdef STALL_PERF_EN
    ,
    .pm_stall_cnt (pm_stall_cnt),
    .dm_stall_cnt (dm_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        pr;
    logic [15:0] pa;
    logic        dr;
    logic [15:0] da;
    logic        w;
    logic        e_pr;
    logic        e_dr;
    logic [3:0]  e_en;
    logic [3:0]  e_bub;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic pr, input logic [15:0] pa,
                     input logic dr, input logic [15:0] da, input logic w,
                     input logic epr, input logic edr, input logic [3:0] een,
                     input logic [3:0] ebub, input logic eb);
    vec_t v;
    v.run = r; v.pr = pr; v.pa = pa; v.dr = dr; v.da = da; v.w = w;
    v.e_pr = epr; v.e_dr = edr; v.e_en = een; v.e_bub = ebub; v.e_busy = eb;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic epr, input logic edr,
                         input logic [3:0] een, input logic [3:0] ebub, input logic eb);
    chk({nm, "_pm_rdy"}, 32'(pm_rdy), 32'(epr));
    chk({nm, "_dm_rdy"}, 32'(dm_rdy), 32'(edr));
    chk({nm, "_en"},     32'(stage_en), 32'(een));
    chk({nm, "_bub"},    32'(bubble), 32'(ebub));
    chk({nm, "_busy"},   32'(busy), 32'(eb));
  endtask

  task automatic drive(input logic r, input logic pr, input logic [15:0] pa,
                       input logic dr, input logic [15:0] da, input logic w);
    run = r; pm_req = pr; pm_add = pa; dm_req = dr; dm_add = da; rwb = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;

    //  run pr  pa        dr  da        rwb | pr dr en       bub      busy
    add(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 4'b1111, 4'b0000, 0); // idle
    add(1, 1, 16'h0100, 0, 16'h0000, 1,  1, 0, 4'b1111, 4'b0000, 0); // fast PM
    add(1, 1, 16'h0100, 1, 16'h0800, 1,  1, 1, 4'b1111, 4'b0000, 0); // fast PM + DM
    add(1, 1, 16'h1FFF, 0, 16'h0000, 1,  0, 0, 4'b1110, 4'b0010, 0); // slow PM t
    add(1, 1, 16'h1FFF, 0, 16'h0000, 1,  0, 0, 4'b1110, 4'b0010, 1); // t+1
    add(1, 1, 16'h1FFF, 0, 16'h0000, 1,  1, 0, 4'b1111, 4'b0000, 1); // t+2 rdy
    add(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 4'b1111, 4'b0000, 0);
    add(1, 0, 16'h0000, 1, 16'h2000, 1,  0, 0, 4'b1000, 4'b1000, 0); // slow DM read t
    add(1, 0, 16'h0000, 1, 16'h2000, 1,  0, 0, 4'b1000, 4'b1000, 1);
    add(1, 0, 16'h0000, 1, 16'h2000, 1,  0, 1, 4'b1111, 4'b0000, 1);
    add(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 4'b1111, 4'b0000, 0);
    add(1, 0, 16'h0000, 1, 16'h2000, 0,  0, 0, 4'b1000, 4'b1000, 0); // slow DM write t
    add(1, 0, 16'h0000, 1, 16'h2000, 0,  0, 1, 4'b1111, 4'b0000, 1);
    add(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 4'b1111, 4'b0000, 0);
    add(1, 1, 16'h1FFF, 1, 16'h2000, 0,  0, 0, 4'b1000, 4'b1000, 0); // PM+DM write t
    add(1, 1, 16'h1FFF, 1, 16'h2000, 0,  0, 1, 4'b1110, 4'b0010, 1);
    add(1, 1, 16'h1FFF, 0, 16'h2000, 0,  1, 0, 4'b1111, 4'b0000, 1);
    add(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 4'b1111, 4'b0000, 0);
    add(0, 1, 16'h0100, 0, 16'h0000, 1,  1, 0, 4'b0000, 4'b0000, 0); // run=0 fast
    add(0, 1, 16'h1FFF, 0, 16'h0000, 1,  0, 0, 4'b0000, 4'b0000, 0); // run=0 slow
    add(0, 1, 16'h1FFF, 0, 16'h0000, 1,  0, 0, 4'b0000, 4'b0000, 1);
    add(0, 1, 16'h1FFF, 0, 16'h0000, 1,  1, 0, 4'b0000, 4'b0000, 1);
    add(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 4'b1111, 4'b0000, 0);
    add(1, 1, 16'h1FFF, 0, 16'h0000, 1,  0, 0, 4'b1110, 4'b0010, 0); // back-to-back
    add(1, 1, 16'h1FFF, 0, 16'h0000, 1,  0, 0, 4'b1110, 4'b0010, 1);
    add(1, 1, 16'h1FFF, 0, 16'h0000, 1,  1, 0, 4'b1111, 4'b0000, 1);
    add(1, 1, 16'h1FFF, 0, 16'h0000, 1,  0, 0, 4'b1110, 4'b0010, 0);
    add(1, 1, 16'h1FFF, 0, 16'h0000, 1,  0, 0, 4'b1110, 4'b0010, 1);
    add(1, 1, 16'h1FFF, 0, 16'h0000, 1,  1, 0, 4'b1111, 4'b0000, 1);
    add(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 4'b1111, 4'b0000, 0);
    add(1, 1, 16'h0FFF, 0, 16'h0000, 1,  1, 0, 4'b1111, 4'b0000, 0); // just below limit
    add(1, 1, 16'h1000, 0, 16'h0000, 1,  0, 0, 4'b1110, 4'b0010, 0); // exactly at limit
    add(1, 0, 16'h1000, 0, 16'h0000, 1,  0, 0, 4'b1111, 4'b0000, 1); // PM abort
    add(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 4'b1111, 4'b0000, 0);
    add(1, 0, 16'h0000, 1, 16'h3000, 1,  0, 0, 4'b1000, 4'b1000, 0); // DM read t
    add(1, 0, 16'h0000, 0, 16'h3000, 1,  0, 0, 4'b1111, 4'b0000, 1); // dropped t+1
    add(1, 0, 16'h0000, 0, 16'h3000, 1,  0, 0, 4'b1111, 4'b0000, 0); // idle, no rdy
    add(1, 0, 16'h0000, 0, 16'h0000, 1,  0, 0, 4'b1111, 4'b0000, 0);

    // Reset with a held fast fetch request.
    rst_n = 1'b0;
    drive(1, 1, 16'h0100, 0, 16'h0000, 1);
    #2;
    chk_all("rst", 0, 0, 4'b0000, 4'b0000, 0);
    @(negedge clk);
    chk_all("rst_hold", 0, 0, 4'b0000, 4'b0000, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk_all("rst_rel", 1, 0, 4'b1111, 4'b0000, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].run, vq[i].pr, vq[i].pa, vq[i].dr, vq[i].da, vq[i].w);
      #2;
      chk_all($sformatf("v%0d", i), vq[i].e_pr, vq[i].e_dr, vq[i].e_en, vq[i].e_bub, vq[i].e_busy);
    end

    // Reset asserted mid-wait, then the held request restarts its full wait.
    @(negedge clk);
    drive(1, 1, 16'h1FFF, 0, 16'h0000, 1);
    #2;
    chk("mw_t_rdy", 32'(pm_rdy), 32'd0);
    @(negedge clk);
    #2;
    chk("mw_t1_busy", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("mw_rst", 0, 0, 4'b0000, 4'b0000, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk_all("mw_r0", 0, 0, 4'b1110, 4'b0010, 0);
    @(negedge clk);
    #2;
    chk_all("mw_r1", 0, 0, 4'b1110, 4'b0010, 1);
    @(negedge clk);
    #2;
    chk_all("mw_r2", 1, 0, 4'b1111, 4'b0000, 1);
    @(negedge clk);
    drive(1, 0, 16'h0000, 0, 16'h0000, 1);

`ifdef STALL_PERF_EN
    rst_n = 1'b0;
    #2;
    chk("perf_rst_pm", pm_stall_cnt, 32'd0);
    chk("perf_rst_dm", dm_stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 1, 16'h1FFF, 0, 16'h0000, 1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      drive(1, 0, 16'h0000, 0, 16'h0000, 1);
    end
    @(negedge clk);
    #2;
    chk("perf_pm", pm_stall_cnt, 32'd6);
    chk("perf_dm", dm_stall_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
